// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// default geometry of the instruction memory.
package instr_loader_pkg;

    localparam int DEPTH_DEFAULT  = 15;
    localparam int ADDR_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_t;

    // A count byte is legal when it names between 1 and depth words.
    function automatic logic count_ok(input logic [7:0] n, input int depth);
        return (n != 8'd0) && (int'(n) <= depth);
    endfunction

endpackage

// File: rtl/instr_loader_checksum.sv
// Running XOR over the word bytes of a load stream.
module loader_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: count, N big-endian 16-bit words, XOR
// checksum; writes instruction memory and holds the CPU while loading.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] word_idx_q;
    logic [ADDR_W-1:0] last_idx_q;
    logic [7:0]        hi_q;
    logic [7:0]        acc;
    logic              xfer;
    logic              launch;
    logic              cs_en;

    loader_checksum u_checksum (
        .clk   (clk),
        .rst_n (reset),
        .clr   (launch),
        .en    (cs_en),
        .din   (byte_data),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        launch     = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                done     = (state_q == ST_DONE);
                error    = (state_q == ST_ERR);
                cpu_hold = (state_q == ST_ERR);
                if (start) begin
                    launch  = 1'b1;
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    state_d = count_ok(byte_data, DEPTH) ? ST_HI : ST_ERR;
                end
            end
            ST_HI: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    state_d = (word_idx_q == last_idx_q) ? ST_CSUM : ST_HI;
                end
            end
            ST_CSUM: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) begin
                    state_d = (byte_data == acc) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign xfer  = byte_valid && byte_ready;
    assign cs_en = xfer && ((state_q == ST_HI) || (state_q == ST_LO));

    // The write is registered so it lands one cycle after the LO byte;
    // address/data only move when a write is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_idx_q <= '0;
            last_idx_q <= '0;
            hi_q       <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (launch) begin
                word_idx_q <= '0;
            end
            if (xfer && state_q == ST_COUNT) begin
                last_idx_q <= ADDR_W'(byte_data - 8'd1);
            end
            if (xfer && state_q == ST_HI) begin
                hi_q <= byte_data;
            end
            if (xfer && state_q == ST_LO) begin
                mem_we     <= 1'b1;
                mem_addr   <= word_idx_q;
                mem_wdata  <= {hi_q, byte_data};
                word_idx_q <= word_idx_q + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench: stream-level reference model plus directed and
// randomized load streams.
module tb_instr_loader;

    localparam int DEPTH  = 15;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = '0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: status 0=idle 1=loading 2=loaded ok 3=failed; pos is the index
    // of the next expected byte in the stream (0=count, 1..2N=words, 2N+1=checksum).
    int                m_status = 0;
    int                m_pos = 0;
    int                m_n = 0;
    logic [7:0]        m_bytes[$];
    logic              m_we = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [15:0]       m_wdata = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_status = 0;
            m_pos    = 0;
            m_n      = 0;
            m_bytes.delete();
            m_we     = 1'b0;
            m_addr   = '0;
            m_wdata  = '0;
        end else begin
            m_we = 1'b0;
            if (m_status != 1) begin
                if (start) begin
                    m_status = 1;
                    m_pos    = 0;
                    m_bytes.delete();
                end
            end else if (byte_valid) begin
                if (m_pos == 0) begin
                    m_n = int'(byte_data);
                    if (m_n == 0 || m_n > DEPTH) m_status = 3;
                    else m_pos = 1;
                end else if (m_pos <= 2 * m_n) begin
                    m_bytes.push_back(byte_data);
                    if (m_pos % 2 == 0) begin
                        m_we    = 1'b1;
                        m_addr  = ADDR_W'(m_pos / 2 - 1);
                        m_wdata = {m_bytes[m_pos-2], byte_data};
                    end
                    m_pos++;
                end else begin
                    logic [7:0] x;
                    x = '0;
                    foreach (m_bytes[i]) x ^= m_bytes[i];
                    m_status = (x == byte_data) ? 2 : 3;
                end
            end
        end
    end

    logic [ADDR_W-1:0] log_addr[$];
    logic [15:0]       log_data[$];

    always @(negedge clk) begin
        check("byte_ready", byte_ready, m_status == 1);
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("cpu_hold", cpu_hold, m_status == 1 || m_status == 3);
        check("done", done, m_status == 2);
        check("error", error, m_status == 3);
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b[$], input int max_gap, input int start_at,
                        output int cycles);
        cycles = 0;
        foreach (b[i]) begin
            if (!byte_ready) break;
            if (max_gap > 0) begin
                int g = int'($urandom_range(max_gap, 0));
                repeat (g) begin
                    byte_valid = 1'b0;
                    tick();
                    cycles++;
                end
            end
            byte_valid = 1'b1;
            byte_data  = b[i];
            start      = (i == start_at);
            tick();
            cycles++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    function automatic int count_addr(input logic [ADDR_W-1:0] a);
        int c = 0;
        foreach (log_addr[i]) if (log_addr[i] == a) c++;
        return c;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[$];
        int cyc;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        tick();
        check("reset_idle_hold", cpu_hold, 1'b0);
        check("reset_idle_ready", byte_ready, 1'b0);

        // Good two-word load
        log_addr.delete(); log_data.delete();
        pulse_start();
        check("load_hold_active", cpu_hold, 1'b1);
        s = '{8'h02, 8'h00, 8'h06, 8'h28, 8'h16, 8'h38};
        send(s, 0, -1, cyc);
        check("good_done", done, 1'b1);
        check("good_hold_released", cpu_hold, 1'b0);
        check("good_nwrites", log_addr.size(), 2);
        check("good_addr0", log_addr[0], 0);
        check("good_data0", log_data[0], 16'h0006);
        check("good_addr1", log_addr[1], 1);
        check("good_data1", log_data[1], 16'h2816);

        // Bad checksum: writes stay, error held
        log_addr.delete(); log_data.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h06, 8'h28, 8'h16, 8'h39};
        send(s, 0, -1, cyc);
        tick();
        check("badcs_error", error, 1'b1);
        check("badcs_hold", cpu_hold, 1'b1);
        check("badcs_done", done, 1'b0);
        check("badcs_nwrites", log_addr.size(), 2);

        // Illegal counts
        for (int k = 0; k < 2; k++) begin
            log_addr.delete(); log_data.delete();
            pulse_start();
            s = '{(k == 0) ? 8'h00 : 8'h10, 8'h12, 8'h34, 8'h26};
            send(s, 0, -1, cyc);
            repeat (2) tick();
            check("badcnt_error", error, 1'b1);
            check("badcnt_nwrites", log_addr.size(), 0);
        end

        // Full-depth back-to-back load
        log_addr.delete(); log_data.delete();
        pulse_start();
        begin
            logic [7:0] x;
            x = '0;
            s = '{8'(DEPTH)};
            for (int i = 0; i < 2 * DEPTH; i++) begin
                s.push_back(8'($urandom));
                x ^= s[s.size()-1];
            end
            s.push_back(x);
        end
        send(s, 0, -1, cyc);
        check("full_cycles", cyc, 32);
        check("full_done", done, 1'b1);
        check("full_nwrites", log_addr.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) check("full_addr", log_addr[i], i);

        // Reset mid-load, after HI byte of word 1
        log_addr.delete(); log_data.delete();
        pulse_start();
        s = '{8'h02, 8'h00, 8'h06, 8'h28};
        send(s, 0, -1, cyc);
        #1 reset = 1'b0;
        #1;
        check("rst_ready", byte_ready, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        tick();
        reset = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'h16;
        repeat (3) tick();
        byte_valid = 1'b0;
        tick();
        check("rst_no_addr1", count_addr(1), 0);
        check("rst_stays_idle", byte_ready, 1'b0);
        pulse_start();
        s = '{8'h02, 8'h00, 8'h06, 8'h28, 8'h16, 8'h38};
        send(s, 0, -1, cyc);
        check("reload_done", done, 1'b1);
        check("reload_addr1", count_addr(1), 1);

        // Start during HI is ignored
        log_addr.delete(); log_data.delete();
        pulse_start();
        send(s, 0, 1, cyc);
        check("starthi_done", done, 1'b1);
        check("starthi_nwrites", log_addr.size(), 2);

        // Randomized streams against the model
        for (int it = 0; it < 60; it++) begin
            int r;
            int n;
            logic [7:0] x;
            int cut;
            if ($urandom_range(3, 0) == 0) begin
                byte_valid = 1'b1;
                byte_data  = 8'($urandom);
                tick();
                byte_valid = 1'b0;
            end
            pulse_start();
            r = int'($urandom_range(15, 0));
            if (r == 0) n = 0;
            else if (r == 1) n = int'($urandom_range(255, 16));
            else n = int'($urandom_range(DEPTH, 1));
            s = '{8'(n)};
            x = '0;
            if (n <= DEPTH) begin
                for (int i = 0; i < 2 * n; i++) begin
                    s.push_back(8'($urandom));
                    x ^= s[s.size()-1];
                end
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                s.push_back(x);
            end
            cut = ($urandom_range(7, 0) == 0) ? int'($urandom_range(s.size() - 1, 0)) : -1;
            if (cut >= 0) while (s.size() > cut) void'(s.pop_back());
            send(s, int'($urandom_range(2, 0)),
                 ($urandom_range(3, 0) == 0) ? int'($urandom_range(s.size(), 0)) : -1, cyc);
            if (cut >= 0) begin
                reset = 1'b0;
                #4;
                reset = 1'b1;
                tick();
            end
            repeat ($urandom_range(3, 1)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
